// File: rtl/imm_pkg.sv
// Shared types and helpers for the rotational immediate encoder.
// Optional MVN search is enabled by IMM_ENCODE_INVERT_EN.
package imm_pkg;

  localparam int ROT_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  function automatic logic [31:0] rol32(
    input logic [31:0] x,
    input logic [4:0]  amt
  );
    logic [63:0] t;
    t = {x, x} << amt;
    return t[63:32];
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Checks one rotation r: rol(cand, 2r) must fit in 8 bits.
// Purely combinational; replicated per rotation lane.
module imm_rot_check
  import imm_pkg::*;
(
  input  logic [31:0] cand,
  input  logic [3:0]  r,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [31:0] rot;

  assign rot   = rol32(cand, {r, 1'b0});
  assign match = (rot[31:8] == 24'd0);
  assign imm8  = rot[7:0];

endmodule

// File: rtl/imm_encoder_rotational.sv
// Multicycle search for the {rot, imm8} encoding of a constant.
// Define IMM_ENCODE_INVERT_EN to retry with ~value after a miss.
module imm_encoder_rotational
  import imm_pkg::*;
#(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        encodable,
  output logic        invert,
  output logic [11:0] imm12
);

  localparam int         NGRP = ROT_STEPS / ROT_PER_CYCLE;
  localparam logic [3:0] LAST = 4'(NGRP - 1);

  state_t      state_q, state_d;
  logic [31:0] cand_q, cand_d;
  logic [3:0]  grp_q, grp_d;
  logic        enc_q, enc_d;
  logic [11:0] imm12_q, imm12_d;
`ifdef IMM_ENCODE_INVERT_EN
  logic        pass_q, pass_d;
  logic        inv_q, inv_d;
`endif

  logic [3:0] r_v   [ROT_PER_CYCLE];
  logic       hit_v [ROT_PER_CYCLE];
  logic [7:0] imm_v [ROT_PER_CYCLE];

  for (genvar i = 0; i < ROT_PER_CYCLE; i++) begin : g_lane
    assign r_v[i] = grp_q * 4'(ROT_PER_CYCLE) + 4'(i);
    imm_rot_check u_chk (
      .cand  (cand_q),
      .r     (r_v[i]),
      .match (hit_v[i]),
      .imm8  (imm_v[i])
    );
  end

  logic       hit;
  logic [3:0] hit_r;
  logic [7:0] hit_imm;

  // Lowest matching rotation in the current group wins.
  always_comb begin
    hit     = 1'b0;
    hit_r   = 4'd0;
    hit_imm = 8'd0;
    for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        hit     = 1'b1;
        hit_r   = r_v[i];
        hit_imm = imm_v[i];
      end
    end
  end

  // Next-state and result capture for IDLE/SEARCH/DONE.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    grp_d   = grp_q;
    enc_d   = enc_q;
    imm12_d = imm12_q;
`ifdef IMM_ENCODE_INVERT_EN
    pass_d  = pass_q;
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cand_d  = value;
          grp_d   = 4'd0;
`ifdef IMM_ENCODE_INVERT_EN
          pass_d  = 1'b0;
`endif
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          enc_d   = 1'b1;
          imm12_d = {hit_r, hit_imm};
`ifdef IMM_ENCODE_INVERT_EN
          inv_d   = pass_q;
`endif
          state_d = DONE;
        end else if (grp_q == LAST) begin
`ifdef IMM_ENCODE_INVERT_EN
          if (!pass_q) begin
            cand_d = ~cand_q;
            pass_d = 1'b1;
            grp_d  = 4'd0;
          end else begin
            enc_d   = 1'b0;
            imm12_d = 12'd0;
            inv_d   = 1'b0;
            state_d = DONE;
          end
`else
          enc_d   = 1'b0;
          imm12_d = 12'd0;
          state_d = DONE;
`endif
        end else begin
          grp_d = grp_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, search context and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cand_q  <= 32'd0;
      grp_q   <= 4'd0;
      enc_q   <= 1'b0;
      imm12_q <= 12'd0;
`ifdef IMM_ENCODE_INVERT_EN
      pass_q  <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      grp_q   <= grp_d;
      enc_q   <= enc_d;
      imm12_q <= imm12_d;
`ifdef IMM_ENCODE_INVERT_EN
      pass_q  <= pass_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign encodable = enc_q;
  assign imm12     = imm12_q;
`ifdef IMM_ENCODE_INVERT_EN
  assign invert    = inv_q;
`else
  assign invert    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder_rotational.sv
// Directed bench for imm_encoder_rotational (N=1 and N=4).
// Expectations adapt when IMM_ENCODE_INVERT_EN is defined.
module tb_imm_encoder_rotational;

`ifdef IMM_ENCODE_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        iv1 = 1'b0, or1 = 1'b0;
  logic [31:0] val1 = 32'd0;
  logic        ir1, ov1, enc1, inv1;
  logic [11:0] imm1;

  logic        iv4 = 1'b0, or4 = 1'b0;
  logic [31:0] val4 = 32'd0;
  logic        ir4, ov4, enc4, inv4;
  logic [11:0] imm4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_encoder_rotational #(.ROT_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv1), .in_ready(ir1), .value(val1),
    .out_valid(ov1), .out_ready(or1),
    .encodable(enc1), .invert(inv1), .imm12(imm1)
  );

  imm_encoder_rotational #(.ROT_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv4), .in_ready(ir4), .value(val4),
    .out_valid(ov4), .out_ready(or4),
    .encodable(enc4), .invert(inv4), .imm12(imm4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input bit f, input logic [31:0] v,
                     output int lat);
    @(negedge clk);
    if (f) begin iv4 = 1'b1; val4 = v; end
    else   begin iv1 = 1'b1; val1 = v; end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if ((f ? ov4 : ov1) === 1'b1) break;
    end
  endtask

  task automatic consume(input bit f);
    @(negedge clk);
    if (f) or4 = 1'b1; else or1 = 1'b1;
    @(posedge clk);
    #1;
    or1 = 1'b0;
    or4 = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [31:0] v,
                      input int elat, input logic eenc,
                      input logic einv, input logic [11:0] eimm);
    int lat;
    req(1'b0, v, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_enc"}, enc1, eenc);
    chk({tag, "_inv"}, inv1, einv);
    chk({tag, "_imm"}, imm1, eimm);
    consume(1'b0);
    chk({tag, "_rdy"}, ir1, 1'b1);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir1, 1'b1);
    chk("rst_out_valid", ov1, 1'b0);
    chk("rst_enc", enc1, 1'b0);
    chk("rst_inv", inv1, 1'b0);
    chk("rst_imm", imm1, 12'h000);
    reset_n = 1'b1;
    @(negedge clk);

    run1("ff", 32'h0000_00FF, 1, 1'b1, 1'b0, 12'h0FF);
    run1("ff000000", 32'hFF00_0000, 5, 1'b1, 1'b0, 12'h4FF);
    run1("3fc", 32'h0000_03FC, 16, 1'b1, 1'b0, 12'hFFF);
    run1("zero", 32'h0000_0000, 1, 1'b1, 1'b0, 12'h000);
    run1("101", 32'h0000_0101, INV ? 32 : 16,
         1'b0, 1'b0, 12'h000);
    run1("mvn", 32'hFFFF_FF00, INV ? 17 : 16,
         INV, INV, INV ? 12'h0FF : 12'h000);
    run1("c0000003", 32'hC000_0003, 2, 1'b1, 1'b0, 12'h10F);

    // Back-pressure: result held, new request ignored.
    req(1'b0, 32'h0000_00FF, lat);
    chk("hold_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv1  = 1'b1;
      val1 = 32'hFF00_0000;
      chk("hold_ov", ov1, 1'b1);
      chk("hold_ir", ir1, 1'b0);
      chk("hold_enc", enc1, 1'b1);
      chk("hold_imm", imm1, 12'h0FF);
    end
    @(negedge clk);
    iv1 = 1'b0;
    consume(1'b0);
    chk("rel_ir", ir1, 1'b1);
    chk("rel_ov", ov1, 1'b0);
    chk("rel_imm", imm1, 12'h0FF);

    // Reset mid-search discards the result.
    @(negedge clk);
    iv1  = 1'b1;
    val1 = 32'h0000_03FC;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("srch_ir", ir1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mrst_ov", ov1, 1'b0);
    chk("mrst_ir", ir1, 1'b1);
    chk("mrst_enc", enc1, 1'b0);
    chk("mrst_imm", imm1, 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    run1("post_rst", 32'hFF00_0000, 5, 1'b1, 1'b0, 12'h4FF);

    // Four rotations per cycle.
    req(1'b1, 32'hFF00_0000, lat);
    chk("n4_ff_lat", lat, 2);
    chk("n4_ff_enc", enc4, 1'b1);
    chk("n4_ff_imm", imm4, 12'h4FF);
    consume(1'b1);
    req(1'b1, 32'h0000_03FC, lat);
    chk("n4_3fc_lat", lat, 4);
    chk("n4_3fc_imm", imm4, 12'hFFF);
    consume(1'b1);
    req(1'b1, 32'h0000_0101, lat);
    chk("n4_101_lat", lat, INV ? 8 : 4);
    chk("n4_101_enc", enc4, 1'b0);
    consume(1'b1);
    chk("n4_rdy", ir4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
